// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and op-classification helpers for the iterative M-extension unit.
package mdu_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_MULW   = 4'd4,
    OP_DIV    = 4'd5,
    OP_DIVU   = 4'd6,
    OP_REM    = 4'd7,
    OP_REMU   = 4'd8,
    OP_DIVW   = 4'd9,
    OP_DIVUW  = 4'd10,
    OP_REMW   = 4'd11,
    OP_REMUW  = 4'd12
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_mulh(input mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  // MUL/MULW use signed magnitudes so the word form fits in 32 iterations.
  function automatic logic is_signed_a(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULW, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic is_signed_b(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULW, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic is_word(input mdu_op_e op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: y = neg ? ~x + cin : x. With cin=1 this is abs()/negate;
// cin lets the high half of a double-width negation take the carry out of the low half.
module mdu_sign_fix #(
  parameter int W = 64
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  input  logic         cin_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + {{(W-1){1'b0}}, cin_i}) : x_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV M-extension unit: shift-add multiplier and restoring radix-2 divider.
// Optional MDU_EARLY_OUT_EN ends MUL early and skips leading dividend zeros in DIV.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OPW  = mdu_pkg::OPW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic s);
    logic [XLEN-1:0] r;
    for (int unsigned i = 0; i < XLEN; i++) r[i] = (i < 32) ? v[i] : (s & v[31]);
    return r;
  endfunction

`ifdef MDU_EARLY_OUT_EN
  function automatic logic [CW-1:0] lead_zeros(input logic [XLEN-1:0] v, input logic [CW-1:0] n);
    logic [CW-1:0] c;
    logic          found;
    c     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if ((XLEN - 1 - i) < n && !found) begin
        if (v[XLEN-1-i]) found = 1'b1;
        else             c     = c + CW'(1);
      end
    end
    return c;
  endfunction
`endif

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d, op_in;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, mplier_q, mplier_d, res_q, res_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              accept, word_in, word_q, sa, sb, b_zero, ovf, mul_last;
  logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, min_w, spec_raw, spec_res;
  logic [CW-1:0]     nbits, lz, div_cnt;
  logic [2*XLEN-1:0] div_init, div_next;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   fix_x, fix_y, fix_res;
  logic              fix_neg, fix_cin;

  assign op_in    = (in_op > OPW'(OP_REMUW)) ? OP_MUL : mdu_op_e'(in_op);
  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready && !flush;

  assign word_in = (XLEN == 64) && is_word(op_in);
  assign word_q  = (XLEN == 64) && is_word(op_q);
  assign a_ext   = word_in ? ext32(in_a, is_signed_a(op_in)) : in_a;
  assign b_ext   = word_in ? ext32(in_b, is_signed_b(op_in)) : in_b;

  assign sa = is_signed_a(op_q) && a_q[XLEN-1];
  assign sb = is_signed_b(op_q) && b_q[XLEN-1];

  mdu_sign_fix #(.W(XLEN)) u_abs_a (.x_i(a_q), .neg_i(sa), .cin_i(1'b1), .y_o(a_abs));
  mdu_sign_fix #(.W(XLEN)) u_abs_b (.x_i(b_q), .neg_i(sb), .cin_i(1'b1), .y_o(b_abs));

  assign nbits    = word_q ? CW'(32) : CW'(XLEN);
  assign b_zero   = (b_q == '0);
  assign min_w    = word_q ? ext32(XLEN'(32'h8000_0000), 1'b1) : MIN_X;
  assign ovf      = is_div(op_q) && is_signed_b(op_q) && (a_q == min_w) && (b_q == '1);
  assign spec_raw = is_rem(op_q) ? (b_zero ? a_q : '0) : (b_zero ? '1 : a_q);
  assign spec_res = word_q ? ext32(spec_raw, 1'b1) : spec_raw;

`ifdef MDU_EARLY_OUT_EN
  assign lz       = lead_zeros(a_abs, nbits);
  assign mul_last = (cnt_q == CW'(1)) || (mplier_q[XLEN-1:1] == '0);
`else
  assign lz       = '0;
  assign mul_last = (cnt_q == CW'(1));
`endif

  // Dividend is left-aligned in the low half so word ops finish in 32 steps.
  assign div_cnt  = nbits - lz;
  assign div_init = {{XLEN{1'b0}}, a_abs << (CW'(XLEN) - nbits + lz)};
  assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q[XLEN-1:0]};
  assign div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // High half of a negated product needs the carry out of the (all-zero) low half.
  assign fix_x   = (is_rem(op_q) || is_mulh(op_q)) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign fix_neg = is_rem(op_q) ? sa : (sa ^ sb);
  assign fix_cin = is_mulh(op_q) ? (acc_q[XLEN-1:0] == '0) : 1'b1;

  mdu_sign_fix #(.W(XLEN)) u_fix (.x_i(fix_x), .neg_i(fix_neg), .cin_i(fix_cin), .y_o(fix_y));

  assign fix_res = word_q ? ext32(fix_y, 1'b1) : fix_y;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          a_d     = a_ext;
          b_d     = b_ext;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (is_div(op_q) && (b_zero || ovf)) begin
          res_d   = spec_res;
          state_d = S_DONE;
        end else if (is_div(op_q)) begin
          mcand_d = {{XLEN{1'b0}}, b_abs};
          acc_d   = div_init;
          cnt_d   = div_cnt;
          state_d = S_DIV;
`ifdef MDU_EARLY_OUT_EN
          if (div_cnt == '0) state_d = S_FIX;
`endif
        end else begin
          mcand_d  = {{XLEN{1'b0}}, a_abs};
          mplier_d = b_abs;
          acc_d    = '0;
          cnt_d    = nbits;
          state_d  = S_MUL;
`ifdef MDU_EARLY_OUT_EN
          if (b_abs == '0) state_d = S_FIX;
`endif
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (mul_last) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = fix_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (XLEN=64): arithmetic reference model, decoupled monitor.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  in_op = '0;
  logic [63:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid;
  logic [63:0] out_result;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  bit          rand_bp = 1'b0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  mdu_iter #(.XLEN(64), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_mdu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, sp;
    logic [127:0]        ua, ub, up;
    logic signed [63:0]  s64a, s64b;
    logic signed [31:0]  s32a, s32b;
    logic [31:0]         a32, b32, r32;
    sa = $signed({{64{a[63]}}, a}); sb = $signed({{64{b[63]}}, b});
    ua = {64'b0, a}; ub = {64'b0, b};
    s64a = $signed(a); s64b = $signed(b);
    a32 = a[31:0]; b32 = b[31:0];
    s32a = $signed(a32); s32b = $signed(b32);
    case (op)
      4'd1: begin sp = sa * sb; return sp[127:64]; end
      4'd2: begin sp = sa * $signed(ub); return sp[127:64]; end
      4'd3: begin up = ua * ub; return up[127:64]; end
      4'd4: begin r32 = a32 * b32; return sx32(r32); end
      4'd5: begin
        if (b == 0) return '1;
        if (a == MIN64 && b == '1) return MIN64;
        return s64a / s64b;
      end
      4'd6: return (b == 0) ? '1 : a / b;
      4'd7: begin
        if (b == 0) return a;
        if (a == MIN64 && b == '1) return 64'd0;
        return s64a % s64b;
      end
      4'd8: return (b == 0) ? a : a % b;
      4'd9: begin
        if (b32 == 0) return '1;
        if (a32 == 32'h8000_0000 && b32 == '1) return sx32(32'h8000_0000);
        r32 = s32a / s32b; return sx32(r32);
      end
      4'd10: begin
        if (b32 == 0) return '1;
        r32 = a32 / b32; return sx32(r32);
      end
      4'd11: begin
        if (b32 == 0) return sx32(a32);
        if (a32 == 32'h8000_0000 && b32 == '1) return 64'd0;
        r32 = s32a % s32b; return sx32(r32);
      end
      4'd12: begin
        if (b32 == 0) return sx32(a32);
        r32 = a32 % b32; return sx32(r32);
      end
      default: return a * b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every transfer is popped and compared against the model's prediction.
  initial forever begin
    @(negedge clk);
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: got %h expected no transfer", out_result);
      end else begin
        check("scoreboard", out_result, exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int k = 0;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && in_ready && !flush) break;
      k++;
      if (k > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL issue_timeout: got in_ready=0 expected accept within 2000 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(ref_mdu(op, a, b));
    #1 in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
    int k = 1;
    issue(op, a, b);
    @(negedge clk);
    while (!out_valid && k < 300) begin @(negedge clk); k++; end
    check({name, "_result"}, out_result, exp);
`ifndef MDU_EARLY_OUT_EN
    check({name, "_latency"}, 64'(k), 64'(lat));
`else
    check({name, "_valid"}, 64'(out_valid), 64'd1);
`endif
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return MIN64;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {32'd0, 32'($urandom)};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    bit   seen;
    int   k;
    logic [63:0] hold;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_result", out_result, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    directed("mul_3_m5", OP_MUL, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 67);
    directed("mulhu_max", OP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 67);
    directed("mulh_m1", OP_MULH, '1, '1, 64'd0, 67);
    directed("mulhsu_m1_2", OP_MULHSU, '1, 64'd2, '1, 67);
    directed("div_by0", OP_DIV, 64'd7, 64'd0, '1, 2);
    directed("rem_by0", OP_REM, 64'd7, 64'd0, 64'd7, 2);
    directed("div_ovf", OP_DIV, MIN64, '1, MIN64, 2);
    directed("rem_ovf", OP_REM, MIN64, '1, 64'd0, 2);
    directed("divw_ovf", OP_DIVW, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2);
    directed("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 67);
    directed("rem_m7_2", OP_REM, -64'sd7, 64'd2, '1, 67);
    directed("mulw_m1_2", OP_MULW, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35);
    directed("divuw", OP_DIVUW, 64'hFFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 35);

    // Backpressure: result held for 10 cycles, then exactly one transfer.
    out_ready = 1'b0;
    issue(OP_DIVU, 64'hDEAD_BEEF_1234_5678, 64'd1000);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 300) begin @(negedge clk); k++; end
    hold = out_result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_stable", out_result, hold);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_after_valid", 64'(out_valid), 64'd0);
    check("bp_after_in_ready", 64'(in_ready), 64'd1);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Flush at cycle 20 of a DIV.
    issue(OP_DIV, 64'h0123_4567_89AB_CDEF, 64'd12345);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (80) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("flush_no_valid", 64'(seen), 64'd0);
    @(posedge clk); #1;
    directed("mul_after_flush", OP_MUL, 64'd123456789, 64'd987654321, 64'd121932631112635269, 67);

    // Reset pulse mid-operation.
    issue(OP_MULHU, '1, 64'h1234_5678_9ABC_DEF0);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_out_result", out_result, 64'd0);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("rst_no_valid", 64'(seen), 64'd0);
    @(posedge clk); #1;
    directed("mul_after_rst", OP_MUL, -64'sd6, -64'sd7, 64'd42, 67);

    // Randomized ops (including illegal codes) under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
    k = 0;
    while (exp_q.size() > 0 && k < 5000) begin @(negedge clk); k++; end
    rand_bp = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
